// File: rtl/dft_crm_pkg.sv
// rtl/dft_crm_pkg.sv - shared types, defaults and config clamp for the CRM dividers
package dft_crm_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    STOP_PEND = 2'd2
  } crm_state_e;

  localparam int DEF_RATIO_C = 3;
  localparam int DEF_HIGH_C  = 1;

  function automatic int unsigned clamp_ratio(input int unsigned ratio);
    return (ratio < 2) ? 2 : ratio;
  endfunction

  // ratio must already be clamped so that ratio-1 is a legal high time
  function automatic int unsigned clamp_high(input int unsigned ratio, input int unsigned high);
    int unsigned h;
    h = (high == 0) ? 1 : high;
    if (h >= ratio) h = ratio - 1;
    return h;
  endfunction

endpackage

// File: rtl/dft_crm_rst_mux.sv
// rtl/dft_crm_rst_mux.sv - DFT reset source select shared by the CRM blocks
module dft_crm_rst_mux (
  input  logic rst_n,
  input  logic test_mode,
  input  logic test_as_reset_b,
  output logic rst_n_mux
);

  assign rst_n_mux = test_mode ? test_as_reset_b : rst_n;

endmodule

// File: rtl/dft_crm_div_prog.sv
// rtl/dft_crm_div_prog.sv - programmable glitch-free integer clock divider
// Ratio/high-time changes are staged in a pend slot and applied at period boundaries.
module dft_crm_div_prog
  import dft_crm_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter int DEF_RATIO = DEF_RATIO_C,
  parameter int DEF_HIGH  = DEF_HIGH_C
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             test_mode,
  input  logic             test_as_reset_b,
  input  logic             test_hs_mode,
  input  logic             test_se,
  input  logic             div_en,
  input  logic             cfg_vld,
  output logic             cfg_rdy,
  input  logic [CNT_W-1:0] cfg_ratio,
  input  logic [CNT_W-1:0] cfg_high,
  output logic             clk_o,
  output logic             clk_en_o,
  output logic [CNT_W-1:0] act_ratio,
  output logic             running
);

  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEF_R_VAL = CNT_W'(DEF_RATIO);
  localparam logic [CNT_W-1:0] DEF_H_VAL = CNT_W'(DEF_HIGH);

  logic rst_n_mux;

  dft_crm_rst_mux u_rst_mux (
    .rst_n           (rst_n),
    .test_mode       (test_mode),
    .test_as_reset_b (test_as_reset_b),
    .rst_n_mux       (rst_n_mux)
  );

  crm_state_e       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] act_high, act_ratio_n, act_high_n;
  logic [CNT_W-1:0] pend_ratio, pend_high, pend_ratio_n, pend_high_n;
  logic [CNT_W-1:0] in_ratio, in_high;
  logic             pend_vld, pend_vld_n;
  logic             clk_o_n, clk_en_q, clk_en_n;
  logic             xfer, boundary, apply, run_n, hs;

  assign cfg_rdy  = ~pend_vld & ~test_se;
  assign xfer     = cfg_vld & cfg_rdy;
  assign running  = (state != IDLE);
  assign clk_en_o = clk_en_q & ~test_se;
  assign hs       = test_mode & test_hs_mode;
  assign boundary = running && (cnt == act_ratio - ONE);

  always_comb begin
    in_ratio     = CNT_W'(clamp_ratio(32'(cfg_ratio)));
    in_high      = CNT_W'(clamp_high(32'(in_ratio), 32'(cfg_high)));
    pend_ratio_n = xfer ? in_ratio : pend_ratio;
    pend_high_n  = xfer ? in_high : pend_high;
    // a transfer landing on a boundary (or in IDLE) is applied on the same edge
    apply        = (xfer | pend_vld) & (boundary | (state == IDLE));
    pend_vld_n   = (xfer | pend_vld) & ~apply;
    act_ratio_n  = apply ? pend_ratio_n : act_ratio;
    act_high_n   = apply ? pend_high_n : act_high;

    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (div_en) state_n = RUN;
      end
      RUN: begin
        cnt_n = boundary ? '0 : cnt + ONE;
        if (!div_en) state_n = boundary ? IDLE : STOP_PEND;
      end
      STOP_PEND: begin
        cnt_n = boundary ? '0 : cnt + ONE;
        if (div_en) state_n = RUN;
        else if (boundary) state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
    if (state_n == IDLE) cnt_n = '0;

    run_n    = (state_n != IDLE);
    clk_o_n  = run_n & (cnt_n < act_high_n);
    clk_en_n = run_n & (cnt_n == act_ratio_n - ONE);

    // at-speed test: plain divide-by-2, divider parked in IDLE
    if (hs) begin
      state_n  = IDLE;
      cnt_n    = '0;
      clk_o_n  = ~clk_o;
      clk_en_n = clk_o;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_mux) begin
    if (!rst_n_mux) begin
      state      <= IDLE;
      cnt        <= '0;
      clk_o      <= 1'b0;
      clk_en_q   <= 1'b0;
      pend_vld   <= 1'b0;
      pend_ratio <= DEF_R_VAL;
      pend_high  <= DEF_H_VAL;
      act_ratio  <= DEF_R_VAL;
      act_high   <= DEF_H_VAL;
    end else if (!test_se) begin
      state      <= state_n;
      cnt        <= cnt_n;
      clk_o      <= clk_o_n;
      clk_en_q   <= clk_en_n;
      pend_vld   <= pend_vld_n;
      pend_ratio <= pend_ratio_n;
      pend_high  <= pend_high_n;
      act_ratio  <= act_ratio_n;
      act_high   <= act_high_n;
    end
  end

endmodule

// File: tb/tb_dft_crm_div_prog.sv
// tb/tb_dft_crm_div_prog.sv - randomized and directed bench for the programmable divider
module tb_dft_crm_div_prog;

  localparam int CNT_W = 8;

  logic             clk_i = 1'b0;
  logic             rst_n = 1'b0;
  logic             test_mode = 1'b0;
  logic             test_as_reset_b = 1'b1;
  logic             test_hs_mode = 1'b0;
  logic             test_se = 1'b0;
  logic             div_en = 1'b0;
  logic             cfg_vld = 1'b0;
  logic             cfg_rdy;
  logic [CNT_W-1:0] cfg_ratio = '0;
  logic [CNT_W-1:0] cfg_high = '0;
  logic             clk_o;
  logic             clk_en_o;
  logic [CNT_W-1:0] act_ratio;
  logic             running;

  always #5 clk_i = ~clk_i;

  dft_crm_div_prog #(.CNT_W(CNT_W), .DEF_RATIO(3), .DEF_HIGH(1)) dut (
    .clk_i           (clk_i),
    .rst_n           (rst_n),
    .test_mode       (test_mode),
    .test_as_reset_b (test_as_reset_b),
    .test_hs_mode    (test_hs_mode),
    .test_se         (test_se),
    .div_en          (div_en),
    .cfg_vld         (cfg_vld),
    .cfg_rdy         (cfg_rdy),
    .cfg_ratio       (cfg_ratio),
    .cfg_high        (cfg_high),
    .clk_o           (clk_o),
    .clk_en_o        (clk_en_o),
    .act_ratio       (act_ratio),
    .running         (running)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: each period is expanded into a queue of (clk_o, clk_en_o) samples.
  bit m_run, m_o, m_en, m_pv;
  int m_ratio, m_high, m_pr, m_ph;
  bit qo[$];
  bit qe[$];

  task automatic m_reset();
    m_run = 0; m_o = 0; m_en = 0; m_pv = 0;
    m_ratio = 3; m_high = 1;
    qo.delete(); qe.delete();
  endtask

  task automatic m_step();
    bit bnd;
    int r, h;
    if (test_se) return;
    if (cfg_vld && !m_pv) begin
      r = (int'(cfg_ratio) < 2) ? 2 : int'(cfg_ratio);
      h = (int'(cfg_high) < 1) ? 1 : int'(cfg_high);
      m_pr = (h > r - 1) ? r : r;
      m_ph = (h > r - 1) ? r - 1 : h;
      m_pv = 1;
    end
    bnd = m_run && (qo.size() == 0);
    if ((!m_run || bnd) && m_pv) begin
      m_ratio = m_pr; m_high = m_ph; m_pv = 0;
    end
    if (test_mode && test_hs_mode) begin
      m_en = m_o; m_o = !m_o; m_run = 0;
      qo.delete(); qe.delete();
    end else if (m_run && !bnd) begin
      m_o = qo.pop_front(); m_en = qe.pop_front();
    end else if (div_en) begin
      for (int i = 0; i < m_ratio; i++) begin
        qo.push_back(i < m_high);
        qe.push_back(i == m_ratio - 1);
      end
      m_o = qo.pop_front(); m_en = qe.pop_front(); m_run = 1;
    end else begin
      m_run = 0; m_o = 0; m_en = 0;
    end
  endtask

  task automatic compare();
    chk("clk_o", clk_o, m_o);
    chk("clk_en_o", clk_en_o, m_en && !test_se);
    chk("running", running, m_run);
    chk("act_ratio", act_ratio, m_ratio);
    chk("cfg_rdy", cfg_rdy, !m_pv && !test_se);
  endtask

  task automatic cycle();
    @(posedge clk_i);
    m_step();
    @(negedge clk_i);
    compare();
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic cfg_write(input int r, input int h);
    bit acc;
    bit done;
    done = 0;
    cfg_ratio = CNT_W'(r);
    cfg_high  = CNT_W'(h);
    cfg_vld   = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      acc = !m_pv && !test_se;
      cycle();
      done = acc;
    end
    cfg_vld = 1'b0;
    if (!done) chk("cfg_timeout", 0, 1);
  endtask

  task automatic wait_pos(input int remaining);
    bit hit;
    hit = m_run && (qo.size() == remaining);
    for (int i = 0; i < 300 && !hit; i++) begin
      cycle();
      hit = m_run && (qo.size() == remaining);
    end
    if (!hit) chk("wait_pos_timeout", 0, 1);
  endtask

  int lows, highs, toggles;
  bit prev_o, hit_hi;
  int se_left;

  initial begin
    m_reset();
    @(negedge clk_i);
    @(negedge clk_i);
    compare();
    rst_n = 1'b1;

    // defaults: 1,0,0 repeating
    div_en = 1'b1;
    cycles(12);
    chk("act_ratio_def", act_ratio, 3);

    // mid-period write of 5/2
    wait_pos(1);
    cfg_write(5, 2);
    lows = !cfg_rdy;
    for (int i = 0; i < 10; i++) begin
      cycle();
      lows += !cfg_rdy;
    end
    chk("cfg_rdy_low_cycles", lows, 1);
    chk("act_ratio_5", act_ratio, 5);

    // clamps
    cfg_write(1, 0);
    cycles(8);
    chk("act_ratio_clamp2", act_ratio, 2);
    cfg_write(4, 7);
    cycles(10);
    chk("act_ratio_4", act_ratio, 4);
    highs = 0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      highs += clk_o;
    end
    chk("high_cnt_4_3", highs, 6);

    // stop on second cycle of a ratio-5 period
    cfg_write(5, 2);
    cycles(12);
    wait_pos(3);
    div_en = 1'b0;
    cycles(8);
    chk("stopped_running", running, 0);
    chk("stopped_clk_o", clk_o, 0);
    div_en = 1'b1;
    cycles(3);

    // scan freeze with an offered config
    wait_pos(2);
    test_se = 1'b1;
    cfg_ratio = 8'd7; cfg_high = 8'd3; cfg_vld = 1'b1;
    cycles(10);
    test_se = 1'b0; cfg_vld = 1'b0;
    cycles(12);
    chk("scan_no_accept", act_ratio, 5);

    // at-speed divide-by-2
    test_mode = 1'b1; test_hs_mode = 1'b1;
    cycle();
    toggles = 0;
    for (int i = 0; i < 8; i++) begin
      prev_o = clk_o;
      cycle();
      toggles += (clk_o != prev_o);
    end
    chk("hs_toggles", toggles, 8);
    test_hs_mode = 1'b0; test_mode = 1'b0;
    cycles(12);

    // randomized run
    se_left = 0;
    for (int n = 0; n < 1500; n++) begin
      div_en = ($urandom_range(0, 9) != 0);
      if (se_left > 0) se_left--;
      else if ($urandom_range(0, 39) == 0) se_left = $urandom_range(1, 5);
      test_se = (se_left > 0);
      cfg_vld = ($urandom_range(0, 5) == 0);
      cfg_ratio = ($urandom_range(0, 15) == 0) ? CNT_W'($urandom_range(0, 40)) : CNT_W'($urandom_range(0, 9));
      cfg_high = CNT_W'($urandom_range(0, 10));
      cycle();
    end
    test_se = 1'b0; cfg_vld = 1'b0; div_en = 1'b1;
    cycles(50);

    // async test reset while clk_o is high
    cfg_write(6, 4);
    cycles(8);
    hit_hi = clk_o;
    for (int i = 0; i < 50 && !hit_hi; i++) begin
      cycle();
      hit_hi = clk_o;
    end
    chk("pre_reset_clk_o_high", clk_o, 1);
    #2;
    test_mode = 1'b1;
    test_as_reset_b = 1'b0;
    #1;
    m_reset();
    chk("test_rst_clk_o", clk_o, 0);
    chk("test_rst_act_ratio", act_ratio, 3);
    chk("test_rst_running", running, 0);
    chk("test_rst_cfg_rdy", cfg_rdy, 1);
    @(negedge clk_i);
    compare();
    test_as_reset_b = 1'b1;
    test_mode = 1'b0;
    cycles(9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
